// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between fpdiv_ctrl and the fpdiv datapath.
// master: the sequencing controller; slave: the requester/datapath side.
interface fpdiv_ctrl_if;
  logic       start;
  logic       en_a;
  logic       en_b;
  logic       en_rem;
  logic [1:0] sel_mux3;
  logic [1:0] sel_mux4;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    output en_a,
    output en_b,
    output en_rem,
    output sel_mux3,
    output sel_mux4,
    output busy,
    output done
  );

  modport slave (
    output start,
    input  en_a,
    input  en_b,
    input  en_rem,
    input  sel_mux3,
    input  sel_mux4,
    input  busy,
    input  done
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: seed multiply, ITER refinement pairs, optional
// remainder product, then a one-cycle done. Moore FSM, outputs decode from state.
// Optional remainder stage is compiled in when FPDIV_REM_EN is defined.
module fpdiv_ctrl #(
  parameter int unsigned ITER = 3
) (
  input logic          clk_i,
  input logic          reset_i,
  fpdiv_ctrl_if.master bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMuln = 3'd1;
  localparam logic [2:0] StMuld = 3'd2;
  localparam logic [2:0] StIta  = 3'd3;
  localparam logic [2:0] StItb  = 3'd4;
`ifdef FPDIV_REM_EN
  localparam logic [2:0] StRem  = 3'd5;
`endif
  localparam logic [2:0] StDone = 3'd6;

  localparam logic [2:0] IterLast = 3'(ITER - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] iter_cnt_q, iter_cnt_d;

  // State and iteration counter registers, synchronous reset to IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      iter_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE and DONE.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StMuln;
          iter_cnt_d = 3'd0;
        end
      end
      StMuln: state_d = StMuld;
      StMuld: state_d = StIta;
      // N path consumes regc before the D path overwrites it.
      StIta:  state_d = StItb;
      StItb: begin
        if (iter_cnt_q < IterLast) begin
          state_d    = StIta;
          iter_cnt_d = iter_cnt_q + 3'd1;
        end else begin
`ifdef FPDIV_REM_EN
          state_d = StRem;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef FPDIV_REM_EN
      StRem:  state_d = StDone;
`endif
      StDone: begin
        if (bus.start) begin
          state_d    = StMuln;
          iter_cnt_d = 3'd0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state only.
  always_comb begin
    bus.en_a     = 1'b0;
    bus.en_b     = 1'b0;
    bus.en_rem   = 1'b0;
    bus.sel_mux3 = 2'd0;
    bus.sel_mux4 = 2'd0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      StMuln: begin
        bus.sel_mux4 = 2'd0;
        bus.en_a     = 1'b1;
        bus.busy     = 1'b1;
      end
      StMuld: begin
        bus.sel_mux4 = 2'd1;
        bus.en_b     = 1'b1;
        bus.busy     = 1'b1;
      end
      StIta: begin
        bus.sel_mux3 = 2'd1;
        bus.sel_mux4 = 2'd2;
        bus.en_a     = 1'b1;
        bus.busy     = 1'b1;
      end
      StItb: begin
        bus.sel_mux3 = 2'd1;
        bus.sel_mux4 = 2'd3;
        bus.en_b     = 1'b1;
        bus.busy     = 1'b1;
      end
`ifdef FPDIV_REM_EN
      StRem: begin
        bus.sel_mux3 = 2'd2;
        bus.sel_mux4 = 2'd2;
        bus.en_rem   = 1'b1;
        bus.busy     = 1'b1;
      end
`endif
      StDone: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: one instance with ITER=3 and one with ITER=1,
// per-cycle output vectors compared against hand-built state tables.
module tb_fpdiv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpdiv_ctrl_if if3 ();
  fpdiv_ctrl_if if1 ();

  fpdiv_ctrl #(.ITER(3)) dut3 (.clk_i(clk), .reset_i(reset), .bus(if3.master));
  fpdiv_ctrl #(.ITER(1)) dut1 (.clk_i(clk), .reset_i(reset), .bus(if1.master));

  int errors = 0;
  int checks = 0;

  // {busy, done, en_a, en_b, en_rem, sel_mux3[1:0], sel_mux4[1:0]}
  localparam logic [8:0] VIdle = 9'b0_0_0_0_0_00_00;
  localparam logic [8:0] VMuln = 9'b1_0_1_0_0_00_00;
  localparam logic [8:0] VMuld = 9'b1_0_0_1_0_00_01;
  localparam logic [8:0] VIta  = 9'b1_0_1_0_0_01_10;
  localparam logic [8:0] VItb  = 9'b1_0_0_1_0_01_11;
  localparam logic [8:0] VRem  = 9'b1_0_0_0_1_10_10;
  localparam logic [8:0] VDone = 9'b0_1_0_0_0_00_00;

`ifdef FPDIV_REM_EN
  localparam int RemCycles = 1;
`else
  localparam int RemCycles = 0;
`endif

  function automatic int lat(input int iter);
    return 2 * iter + 3 + RemCycles;
  endfunction

  // Expected outputs in cycle k after the start edge (k=1 is MULN).
  function automatic logic [8:0] exp_vec(input int iter, input int k);
    if (k == 1) return VMuln;
    if (k == 2) return VMuld;
    if (k <= 2 * iter + 2) return ((k - 3) % 2 == 0) ? VIta : VItb;
    if (RemCycles == 1 && k == 2 * iter + 3) return VRem;
    if (k == lat(iter)) return VDone;
    return VIdle;
  endfunction

  function automatic logic [8:0] get_out(input int which);
    if (which == 3)
      return {if3.busy, if3.done, if3.en_a, if3.en_b, if3.en_rem, if3.sel_mux3, if3.sel_mux4};
    return {if1.busy, if1.done, if1.en_a, if1.en_b, if1.en_rem, if1.sel_mux3, if1.sel_mux4};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check cycles from..to of a division on one instance; wrap folds back-to-back runs.
  task automatic check_cycles(input int which, input int iter, input int from_k,
                              input int to_k, input bit wrap);
    for (int k = from_k; k <= to_k; k++) begin
      int kk;
      kk = wrap ? ((k - 1) % lat(iter)) + 1 : k;
      check($sformatf("d%0d_c%0d", which, k), 32'(get_out(which)), 32'(exp_vec(iter, kk)));
      tick();
    end
  endtask

  initial begin
    if3.start = 1'b0;
    if1.start = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset with start low.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_idle3_%0d", i), 32'(get_out(3)), 32'(VIdle));
      check($sformatf("rst_idle1_%0d", i), 32'(get_out(1)), 32'(VIdle));
      tick();
    end

    // Single division, ITER=3, then back to IDLE.
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    check_cycles(3, 3, 1, lat(3) + 2, 1'b0);

    // Start held high: ignored while busy, DONE chains straight into MULN.
    if3.start = 1'b1;
    tick();
    check_cycles(3, 3, 1, 2 * lat(3) - 1, 1'b1);
    check("b2b_done2", 32'(get_out(3)), 32'(VDone));
    if3.start = 1'b0;
    tick();
    check("b2b_idle", 32'(get_out(3)), 32'(VIdle));

    // Reset in cycle 5, with start also high: reset wins, next cycle IDLE.
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    check_cycles(3, 3, 1, 4, 1'b0);
    check("mid_c5", 32'(get_out(3)), 32'(exp_vec(3, 5)));
    reset = 1'b1;
    if3.start = 1'b1;
    tick();
    reset = 1'b0;
    if3.start = 1'b0;
    check("mid_rst_idle", 32'(get_out(3)), 32'(VIdle));
    tick();
    check("mid_rst_stay", 32'(get_out(3)), 32'(VIdle));
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    check_cycles(3, 3, 1, lat(3) + 1, 1'b0);

    // ITER=1 instance: short sequence.
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check_cycles(1, 1, 1, lat(1) + 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
